// File: rtl/mem_ahb.sv
// AHB-Lite on-chip memory slave: boot ROM or byte-strobed scratch RAM with
// programmable wait states and a two-cycle ERROR response for illegal writes.
package mem_ahb_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned PA_BITS;
  } cvw_t;

  localparam cvw_t MEM_AHB_DEFAULT_CFG = '{XLEN: 64, PA_BITS: 56};
endpackage

module mem_ahb
  import mem_ahb_pkg::*;
#(
  parameter cvw_t            P           = MEM_AHB_DEFAULT_CFG,
  parameter longint unsigned BASE        = 0,
  parameter longint unsigned RANGE       = 65535,
  parameter int unsigned     WAIT_STATES = 0,
  parameter bit              WRITABLE    = 1'b0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSELMem,
  input  logic [P.PA_BITS-1:0]   HADDR,
  input  logic                   HWRITE,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic [P.XLEN-1:0]      HWDATA,
  input  logic [P.XLEN/8-1:0]    HWSTRB,
  output logic [P.XLEN-1:0]      HREADMem,
  output logic                   HRESPMem,
  output logic                   HREADYMem
);

  localparam int unsigned XLEN       = P.XLEN;
  localparam int unsigned NB         = XLEN / 8;
  localparam int unsigned OFFSET     = $clog2(NB);
  localparam int unsigned ADDR_WIDTH = $clog2(RANGE / 8);
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  write_q;
  logic                  wr_dphase_q;
  logic                  hready_q;
  logic                  hresp_q;
  logic [XLEN-1:0]       rdata_q;
  logic [XLEN-1:0]       mem_q [DEPTH];

  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] a_idx_c;
  logic [XLEN-1:0]       byp_rdata_c;
  logic                  unused_in;

  assign accept_c  = HSELMem & HREADY & HTRANS[1];
  assign a_idx_c   = HADDR[ADDR_WIDTH+OFFSET-1:OFFSET];
  assign unused_in = ^{HADDR, HTRANS[0], 64'(BASE)};

  assign HREADMem  = rdata_q;
  assign HRESPMem  = hresp_q;
  assign HREADYMem = hready_q;

  // Zero-wait read path: forward lanes of a write committing this very cycle.
  always_comb begin
    byp_rdata_c = mem_q[a_idx_c];
    if (wr_dphase_q && (idx_q == a_idx_c)) begin
      for (int b = 0; b < NB; b++) begin
        if (HWSTRB[b]) byp_rdata_c[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
    end
  end

  // Transfer FSM with registered bus responses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wr_dphase_q <= 1'b0;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wr_dphase_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= IDLE;
            hready_q    <= 1'b1;
            wr_dphase_q <= write_q;
            if (!write_q) rdata_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ERR1: begin
          state_q  <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          // IDLE and ERR2 both end with HREADYMem high, so a new address may land.
          state_q  <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (accept_c) begin
            idx_q   <= a_idx_c;
            write_q <= HWRITE;
            if (HWRITE && !WRITABLE) begin
              state_q  <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state_q  <= WAIT;
              hready_q <= 1'b0;
              cnt_q    <= CNT_INIT;
            end else begin
              wr_dphase_q <= HWRITE;
              if (!HWRITE) rdata_q <= byp_rdata_c;
            end
          end
        end
      endcase
    end
  end

  // Storage array; contents survive reset, and only completing writes update it.
  always_ff @(posedge HCLK) begin
    if (wr_dphase_q) begin
      for (int b = 0; b < NB; b++) begin
        if (HWSTRB[b]) mem_q[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

endmodule
